spi_master_gen: RTL and testbench

Parametrised, multi-mode SPI master and successor to the fixed 4-byte master. Each transaction is launched through a start/ready handshake, and the block latches all transfer settings at launch: length 1..C bits, SPI mode (CPOL/CPHA), bit order, clock divisor and slave target. A one-cycle `valid` pulse reports the received word. The block sits between register/control logic on `CLK_IN` and external SPI slaves (DAC, sensor configuration).

---
 rtl/spi_master_gen_pkg.sv | 19 +
 rtl/spi_master_gen_clk_tick.sv | 34 +++
 rtl/spi_master_gen.sv | 245 ++++++++++++++++++++++++
 tb/tb_spi_master_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_gen_pkg.sv
// rtl/spi_master_gen_pkg.sv - shared FSM state type and transfer-length clamp for spi_master_gen
//
// Package spi_master_pkg
//   spi_state_e : controller states IDLE / SETUP / SHIFT / HOLD
//   eff_len()   : maps a requested length of 0 or above the maximum onto the maximum
package spi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    function automatic int eff_len(input int len, input int c);
        return (len == 0 || len > c) ? c : len;
    endfunction

endpackage

// File: rtl/spi_master_gen_clk_tick.sv
// rtl/spi_master_gen_clk_tick.sv - half-period tick generator for the SPI serial clock
//
// Module spi_clk_tick
//   clk    in        : system clock
//   rst    in        : synchronous active-high reset
//   reload in        : restart the count; no tick while asserted
//   div    in DIV_W  : tick period is div+1 clk cycles
//   tick   out       : one-cycle pulse on the last cycle of each period
module spi_clk_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == div) && !reload;
        cnt_d = (reload || tick) ? '0 : cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// rtl/spi_master_gen.sv - parametrised multi-mode SPI master with start/ready launch and valid pulse
//
// Module spi_master_gen (optional feature macro: SPI_MASTER_GEN_SS_HOLD_EN)
//   CLK_IN, RST_IN      : system clock, synchronous active-high reset
//   MISO / MOSI         : serial data in / out
//   SPI_CLK, SPI_SS[N]  : serial clock, active-low slave selects
//   din[C], len         : transmit word (right-justified) and length (0 or >C means C)
//   target[N]           : active-high slave mask
//   CPOL, CPHA          : SPI mode
//   lsb_first, div      : bit order, half-period = div+1 cycles
//   start / ready       : launch handshake
//   dout[C] / valid     : received word and its one-cycle completion pulse
//   hold (macro only)   : keep SS asserted after completion
module spi_master_gen #(
    parameter int N     = 1,
    parameter int C     = 32,
    parameter int DIV_W = 16,
    localparam int LEN_W = $clog2(C + 1)
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             MISO,
    output logic             MOSI,
    output logic             SPI_CLK,
    output logic [N-1:0]     SPI_SS,
    input  logic [C-1:0]     din,
    input  logic [LEN_W-1:0] len,
    input  logic [N-1:0]     target,
    input  logic             CPOL,
    input  logic             CPHA,
    input  logic             lsb_first,
    input  logic [DIV_W-1:0] div,
    input  logic             start,
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
    input  logic             hold,
`endif
    output logic             ready,
    output logic [C-1:0]     dout,
    output logic             valid
);

    import spi_master_pkg::*;

    spi_state_e       state_q, state_d;
    logic [C-1:0]     din_q, din_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic             lsb_q, lsb_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LEN_W:0]   hp_q, hp_d;
    logic [LEN_W-1:0] bit_q, bit_d;
    logic [C-1:0]     rx_q, rx_d;
    logic [C-1:0]     dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     ss_q, ss_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
    logic             hold_q, hold_d;
`endif

    logic             tick;
    logic [LEN_W-1:0] len_in_eff;
    logic [LEN_W-1:0] first_pos;
    logic [LEN_W-1:0] bit_nxt;
    logic [LEN_W-1:0] cur_pos;
    logic [LEN_W-1:0] nxt_pos;
    logic [C-1:0]     cur_onehot;
    logic [C-1:0]     nxt_onehot;
    logic [LEN_W:0]   hp_last;
    logic             leading;

    spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (CLK_IN),
        .rst    (RST_IN),
        .reload (state_q == ST_IDLE),
        .div    (div_q),
        .tick   (tick)
    );

    // Bit k of the transfer lives at din/dout position k (LSB first) or L-1-k (MSB first).
    always_comb begin
        len_in_eff = LEN_W'(eff_len(int'(len), C));
        first_pos  = lsb_first ? '0 : len_in_eff - LEN_W'(1);
        bit_nxt    = bit_q + LEN_W'(1);
        cur_pos    = lsb_q ? bit_q : len_q - LEN_W'(1) - bit_q;
        nxt_pos    = lsb_q ? bit_nxt : len_q - LEN_W'(1) - bit_nxt;
        cur_onehot = C'(1) << cur_pos;
        nxt_onehot = C'(1) << nxt_pos;
        hp_last    = {len_q, 1'b0} - (LEN_W + 1)'(1);
        // Even half-period ticks are the edge moving away from CPOL.
        leading    = !hp_q[0];
    end

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        len_d   = len_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        div_d   = div_q;
        hp_d    = hp_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
        hold_d  = hold_q;
`endif

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol_q;
                mosi_d = 1'b0;
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
                if (!hold) begin
                    ss_d = '1;
                end
`endif
                if (start) begin
                    din_d   = din;
                    len_d   = len_in_eff;
                    cpol_d  = CPOL;
                    cpha_d  = CPHA;
                    lsb_d   = lsb_first;
                    div_d   = div;
                    hp_d    = '0;
                    bit_d   = '0;
                    rx_d    = '0;
                    sclk_d  = CPOL;
                    ss_d    = ~target;
                    mosi_d  = CPHA ? 1'b0 : |(din & (C'(1) << first_pos));
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
                    hold_d  = hold;
`endif
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    hp_d   = hp_q + (LEN_W + 1)'(1);
                    if (!cpha_q) begin
                        if (leading) begin
                            rx_d = rx_q | (MISO ? cur_onehot : '0);
                        end else begin
                            bit_d  = bit_nxt;
                            mosi_d = (bit_nxt < len_q) ? |(din_q & nxt_onehot) : 1'b0;
                        end
                    end else begin
                        if (leading) begin
                            mosi_d = |(din_q & cur_onehot);
                        end else begin
                            rx_d  = rx_q | (MISO ? cur_onehot : '0);
                            bit_d = bit_nxt;
                        end
                    end
                    if (hp_q == hp_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (tick) begin
                    dout_d  = rx_q;
                    valid_d = 1'b1;
                    mosi_d  = 1'b0;
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
                    ss_d    = hold_q ? ss_q : '1;
`else
                    ss_d    = '1;
`endif
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state_q <= ST_IDLE;
            din_q   <= '0;
            len_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            div_q   <= '0;
            hp_q    <= '0;
            bit_q   <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ss_q    <= '1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
            hold_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            len_q   <= len_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            div_q   <= div_d;
            hp_q    <= hp_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign dout    = dout_q;
    assign valid   = valid_q;
    assign SPI_SS  = ss_q;
    assign SPI_CLK = sclk_q;
    assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// tb/tb_spi_master_gen.sv - scoreboard bench for spi_master_gen with a behavioural SPI slave
module tb_spi_master_gen;

    localparam int N     = 4;
    localparam int C     = 32;
    localparam int DIV_W = 16;
    localparam int LEN_W = 6;

    logic             CLK_IN = 1'b0;
    logic             RST_IN;
    logic             MISO;
    logic             MOSI;
    logic             SPI_CLK;
    logic [N-1:0]     SPI_SS;
    logic [C-1:0]     din;
    logic [LEN_W-1:0] len;
    logic [N-1:0]     target;
    logic             CPOL;
    logic             CPHA;
    logic             lsb_first;
    logic [DIV_W-1:0] div;
    logic             start;
    logic             ready;
    logic [C-1:0]     dout;
    logic             valid;
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
    logic             hold_r = 1'b0;
`endif

    spi_master_gen #(.N(N), .C(C), .DIV_W(DIV_W)) dut (
        .CLK_IN    (CLK_IN),
        .RST_IN    (RST_IN),
        .MISO      (MISO),
        .MOSI      (MOSI),
        .SPI_CLK   (SPI_CLK),
        .SPI_SS    (SPI_SS),
        .din       (din),
        .len       (len),
        .target    (target),
        .CPOL      (CPOL),
        .CPHA      (CPHA),
        .lsb_first (lsb_first),
        .div       (div),
        .start     (start),
`ifdef SPI_MASTER_GEN_SS_HOLD_EN
        .hold      (hold_r),
`endif
        .ready     (ready),
        .dout      (dout),
        .valid     (valid)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int rise_cnt  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Behavioural slave, evaluated on the falling system clock edge.
    bit          s_cpol = 0, s_cpha = 0, s_lsb = 0, loop_en = 0;
    int          s_len = 8;
    logic [31:0] s_resp = '0, cap = '0, cap_done = '0;
    int          k = 0;
    logic        prev_clk = 1'b0;
    logic        miso_r = 1'b0;
    wire         ss_all = &SPI_SS;

    assign MISO = loop_en ? MOSI : miso_r;

    function automatic logic rbit(input int idx);
        if (idx >= s_len) return 1'b0;
        return s_lsb ? s_resp[idx] : s_resp[s_len-1-idx];
    endfunction

    task automatic slave_capture();
        if (k < s_len) cap[s_lsb ? k : s_len-1-k] = MOSI;
        if (k == s_len - 1) cap_done = cap;
    endtask

    always @(negedge CLK_IN) begin
        if (ss_all) begin
            k = 0;
            cap = '0;
            prev_clk = s_cpol;
            miso_r = s_cpha ? 1'b0 : rbit(0);
        end else if (SPI_CLK !== prev_clk) begin
            prev_clk = SPI_CLK;
            if (SPI_CLK !== s_cpol) begin
                if (!s_cpha) slave_capture();
                else miso_r = rbit(k);
            end else begin
                if (!s_cpha) begin
                    k++;
                    miso_r = rbit(k);
                end else begin
                    slave_capture();
                    k++;
                end
            end
        end
    end

    always @(posedge SPI_CLK) rise_cnt++;

    // Scoreboard: every valid pulse retires the oldest expected word.
    always @(negedge CLK_IN) begin
        if (valid) begin
            valid_cnt++;
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("sb_dout", dout, exp_q.pop_front());
        end
    end

    task automatic slave_cfg(input bit cp, input bit ch, input bit lf, input int el,
                             input logic [31:0] resp, input bit lp);
        @(negedge CLK_IN);
        s_cpol = cp; s_cpha = ch; s_lsb = lf; s_len = el; s_resp = resp; loop_en = lp;
    endtask

    task automatic do_xfer(input string tag, input logic [31:0] d, input logic [5:0] l,
                           input int el, input logic [3:0] tgt, input bit cp, input bit ch,
                           input bit lf, input logic [15:0] dv, input bit lp,
                           input logic [31:0] resp, input logic [3:0] ess);
        logic [31:0] mask;
        int n, lat, lim;
        mask = (el >= 32) ? 32'hffff_ffff : ((32'd1 << el) - 32'd1);
        lat  = 1 + (2 * el + 2) * (int'(dv) + 1);
        lim  = lat + 20;
        slave_cfg(cp, ch, lf, el, resp, lp);
        @(negedge CLK_IN);
        din = d; len = l; target = tgt; CPOL = cp; CPHA = ch; lsb_first = lf; div = dv;
        start = 1'b1;
        exp_q.push_back(lp ? (d & mask) : (resp & mask));
        @(posedge CLK_IN);
        @(negedge CLK_IN);
        start = 1'b0;
        rise_cnt = 0;
        n = 1;
        while (!valid && n < lim) begin
            @(negedge CLK_IN);
            n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_rises"}, rise_cnt, el);
        check({tag, "_mosi"}, cap_done, d & mask);
        check({tag, "_ss_end"}, SPI_SS, ess);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_sclk_idle"}, SPI_CLK, cp);
        check({tag, "_mosi_idle"}, MOSI, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, vcnt0;
        logic [3:0] ss_seen;
        logic [31:0] r;

        RST_IN = 1'b1; start = 1'b0; din = '0; len = '0; target = '0;
        CPOL = 1'b0; CPHA = 1'b0; lsb_first = 1'b0; div = '0;
        repeat (3) @(negedge CLK_IN);
        check("rst_ss", SPI_SS, 4'hf);
        check("rst_sclk", SPI_CLK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_dout", dout, 0);
        RST_IN = 1'b0;

        // Mode 0, MSB first, L=8, div=1, loopback.
        do_xfer("m0_a5", 32'hA5, 6'd8, 8, 4'b0001, 0, 0, 0, 16'd1, 1, 32'h0, 4'hf);
        // Mode 3, LSB first, L=16, slave answers 0xBEEF.
        do_xfer("m3_lsb", 32'h1234, 6'd16, 16, 4'b0001, 1, 1, 1, 16'd2, 0, 32'hBEEF, 4'hf);
        // Length clamp: 0 and 40 both mean 32 bits.
        r = $urandom;
        do_xfer("len0", r, 6'd0, 32, 4'b0001, 0, 0, 0, 16'd0, 1, 32'h0, 4'hf);
        r = $urandom;
        do_xfer("len40", r, 6'd40, 32, 4'b0001, 0, 1, 1, 16'd0, 0, ~r, 4'hf);
        do_xfer("len1", 32'h1, 6'd1, 1, 4'b0001, 1, 0, 0, 16'd0, 1, 32'h0, 4'hf);

        // Target 4'b0100 with start held high: busy-time changes ignored, back-to-back accept.
        slave_cfg(0, 1, 0, 8, 32'h3C, 0);
        @(negedge CLK_IN);
        din = 32'h5A; len = 6'd8; target = 4'b0100; CPOL = 0; CPHA = 1; lsb_first = 0;
        div = 16'd0; start = 1'b1;
        exp_q.push_back(32'h3C);
        @(posedge CLK_IN);
        @(negedge CLK_IN);
        n = 1;
        ss_seen = ~SPI_SS;
        while (!valid && n < 60) begin
            if (n == 5) din = 32'hFF;
            @(negedge CLK_IN);
            n++;
            ss_seen |= ~SPI_SS;
        end
        check("tgt_latency", n, 19);
        check("tgt_ss_mask", ss_seen, 4'b0100);
        check("tgt_mosi", cap_done, 32'h5A);
        check("tgt_ready_at_valid", ready, 1);
        s_resp = 32'hC3;
        exp_q.push_back(32'hC3);
        @(posedge CLK_IN);
        @(negedge CLK_IN);
        check("b2b_busy", ready, 0);
        check("b2b_ss", SPI_SS, 4'b1011);
        start = 1'b0;
        n = 1;
        while (!valid && n < 60) begin
            @(negedge CLK_IN);
            n++;
        end
        check("b2b_latency", n, 19);
        check("b2b_mosi", cap_done, 32'hFF);

        // Reset in the middle of SHIFT.
        slave_cfg(0, 0, 0, 16, 32'h0, 1);
        @(negedge CLK_IN);
        din = 32'hFFFF; len = 6'd16; target = 4'b0001; CPOL = 0; CPHA = 0; lsb_first = 0;
        div = 16'd3; start = 1'b1;
        @(posedge CLK_IN);
        @(negedge CLK_IN);
        start = 1'b0;
        vcnt0 = valid_cnt;
        repeat (20) @(negedge CLK_IN);
        RST_IN = 1'b1;
        @(posedge CLK_IN);
        @(negedge CLK_IN);
        check("mrst_ss", SPI_SS, 4'hf);
        check("mrst_ready", ready, 1);
        check("mrst_valid", valid, 0);
        check("mrst_dout", dout, 0);
        check("mrst_mosi", MOSI, 0);
        RST_IN = 1'b0;
        repeat (150) @(negedge CLK_IN);
        check("mrst_no_valid", valid_cnt, vcnt0);

`ifdef SPI_MASTER_GEN_SS_HOLD_EN
        hold_r = 1'b1;
        do_xfer("hold1", 32'h81, 6'd8, 8, 4'b0010, 0, 0, 0, 16'd0, 1, 32'h0, 4'b1101);
        repeat (3) @(negedge CLK_IN);
        check("hold_gap_ss", SPI_SS, 4'b1101);
        do_xfer("hold2", 32'h7E, 6'd8, 8, 4'b0010, 0, 0, 1, 16'd1, 1, 32'h0, 4'b1101);
        @(negedge CLK_IN);
        hold_r = 1'b0;
        check("hold_release_pre", SPI_SS, 4'b1101);
        @(negedge CLK_IN);
        check("hold_release", SPI_SS, 4'hf);
`endif

        repeat (5) @(negedge CLK_IN);
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
